// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Debounces N_BTN independent mechanical push buttons. Each raw input goes
// through a two-flop synchronizer. A small per-channel FSM accepts a new level
// only after the synchronized input has been stable long enough. The FSM
// tracks a stable level (IDLE / HIGH) and a candidate level (WAIT_HIGH /
// WAIT_LOW). A per-channel counter measures how long the candidate level has
// been seen.
//
// Ports
//   clock      in   1      rising-edge clock for all state
//   i_reset    in   1      synchronous, active-low reset
//   i_btn      in   N_BTN  raw asynchronous button levels, 1 = pressed
//   o_level    out  N_BTN  debounced, registered button level
//   o_press    out  N_BTN  one-cycle pulse on each accepted 0->1 change
//   o_release  out  N_BTN  one-cycle pulse on each accepted 1->0 change
//
// Parameters
//   N_BTN      number of independent channels
//   DB_CYCLES  stability window in clock cycles (2 .. 2**24)
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int N_BTN     = 4,
   parameter int DB_CYCLES = 1000000
) (
   input  logic             clock,
   input  logic             i_reset,
   input  logic [N_BTN-1:0] i_btn,
   output logic [N_BTN-1:0] o_level,
   output logic [N_BTN-1:0] o_press,
   output logic [N_BTN-1:0] o_release
);

   // Counter only has to reach DB_CYCLES-1, so clog2(DB_CYCLES) bits suffice.
   localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   logic [N_BTN-1:0] meta;
   logic [N_BTN-1:0] sync;

   // Two-flop synchronizer; only the second stage feeds the channel FSMs.
   always_ff @(posedge clock) begin
      if (!i_reset) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= i_btn;
         sync <= meta;
      end
   end

   for (genvar n = 0; n < N_BTN; n++) begin : g_ch
      state_t        state;
      state_t        state_nxt;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_nxt;
      logic          press_nxt;
      logic          release_nxt;
      logic          level_nxt;
      logic          level;
      logic          press;
      logic          rel;

      // Next-state, counter and pulse decode for this channel.
      always_comb begin
         state_nxt   = state;
         cnt_nxt     = '0;
         press_nxt   = 1'b0;
         release_nxt = 1'b0;
         case (state)
            IDLE: begin
               if (sync[n]) begin
                  state_nxt = WAIT_HIGH;
               end else begin
                  state_nxt = IDLE;
               end
            end
            WAIT_HIGH: begin
               if (!sync[n]) begin
                  state_nxt = IDLE;            // bounce: abandon, no pulse
               end else if (cnt == CNT_MAX) begin
                  state_nxt = HIGH;
                  press_nxt = 1'b1;
               end else begin
                  state_nxt = WAIT_HIGH;
                  cnt_nxt   = cnt + 1'b1;
               end
            end
            HIGH: begin
               if (!sync[n]) begin
                  state_nxt = WAIT_LOW;
               end else begin
                  state_nxt = HIGH;
               end
            end
            WAIT_LOW: begin
               if (sync[n]) begin
                  state_nxt = HIGH;            // bounce: abandon, no pulse
               end else if (cnt == CNT_MAX) begin
                  state_nxt   = IDLE;
                  release_nxt = 1'b1;
               end else begin
                  state_nxt = WAIT_LOW;
                  cnt_nxt   = cnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
         // The level is decoded from the next state so it rises together
         // with the press pulse on the accepting edge.
         level_nxt = (state_nxt == HIGH) || (state_nxt == WAIT_LOW);
      end

      // State, counter and registered outputs for this channel.
      always_ff @(posedge clock) begin
         if (!i_reset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            rel   <= release_nxt;
         end
      end

      assign o_level[n]   = level;
      assign o_press[n]   = press;
      assign o_release[n] = rel;
   end

endmodule
